// File: rtl/tlc5615_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlc5615_pkg
// Description : Shared types and constants for the TLC5615 serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package tlc5615_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 10;
    localparam int PAD_HI     = 4;
    localparam int PAD_LO     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_t;

    // The DAC wants four leading don't-care bits and two trailing sub-LSB zeros.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [DATA_BITS-1:0] sample);
        return {{PAD_HI{1'b0}}, sample, {PAD_LO{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlc5615_sclk_tick.sv
`default_nettype none
// ============================================================================
// Module      : tlc5615_sclk_tick
// Description : SCLK half-period divider; half_tick marks the last clk of
//               every CLK_DIV-cycle interval while enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc5615_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic half_tick
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    assign half_tick = en && (r_cnt == c_DIV_LAST);

    // Held at zero while disabled so every enabled interval starts aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!en || half_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlc5615_tx.sv
`default_nettype none
// ============================================================================
// Module      : tlc5615_tx
// Description : Valid/ready sample input, 16-bit MSB-first SPI frames to the
//               TLC5615 DAC. Optional one-entry holding buffer is enabled by
//               defining TLC5615_TX_HOLD_BUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tlc5615_tx
    import tlc5615_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] sample_in,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 dac_cs_n,
    output logic                 dac_sclk,
    output logic                 dac_din,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int                 c_GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);
    localparam logic [3:0]         c_BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_t              r_state;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [3:0]             r_bit_cnt;
    logic                   r_phase;
    logic [c_GAP_W-1:0]     r_gap_cnt;
    logic                   r_cs_n;
    logic                   r_sclk;
    logic                   r_din;
    logic                   r_busy;
    logic                   r_frame_done;
    logic                   r_ready;

    logic                   w_tick_en;
    logic                   w_half_tick;
    logic                   w_accept;
    logic                   w_gap_end;
    logic [DATA_BITS-1:0]   w_launch_data;
    logic [FRAME_BITS-1:0]  w_launch_word;

    assign w_tick_en = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
    assign w_accept  = sample_valid && r_ready;
    assign w_gap_end = (r_state == ST_GAP) && (r_gap_cnt == c_GAP_LAST);

`ifdef TLC5615_TX_HOLD_BUF_EN
    logic                 r_buf_full;
    logic [DATA_BITS-1:0] r_buf_data;
    logic                 w_buf_push;

    // A sample offered on the last GAP cycle with an empty buffer launches directly.
    assign w_buf_push    = w_accept && (r_state != ST_IDLE) && !w_gap_end;
    assign w_launch_data = r_buf_full ? r_buf_data : sample_in;
`else
    assign w_launch_data = sample_in;
`endif

    assign w_launch_word = make_frame(w_launch_data);

    tlc5615_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (w_tick_en),
        .half_tick (w_half_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_phase      <= 1'b0;
            r_gap_cnt    <= '0;
            r_cs_n       <= 1'b1;
            r_sclk       <= 1'b0;
            r_din        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_ready      <= 1'b0;
`ifdef TLC5615_TX_HOLD_BUF_EN
            r_buf_full   <= 1'b0;
            r_buf_data   <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SETUP;
                        r_shift <= w_launch_word;
                        r_din   <= w_launch_word[FRAME_BITS-1];
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
`ifdef TLC5615_TX_HOLD_BUF_EN
                    r_ready <= 1'b1;
`else
                    r_ready <= !w_accept;
`endif
                end
                ST_SETUP: begin
                    if (w_half_tick) begin
                        r_state   <= ST_SHIFT;
                        r_bit_cnt <= '0;
                        r_phase   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (w_half_tick) begin
                        if (!r_phase) begin
                            r_sclk  <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            // Falling edge: the next bit is presented while SCLK is low.
                            r_sclk  <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bit_cnt == c_BIT_LAST) begin
                                r_state <= ST_HOLD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                                r_din     <= r_shift[FRAME_BITS-2];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_half_tick) begin
                        r_state      <= ST_GAP;
                        r_cs_n       <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_gap_cnt    <= '0;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
`ifdef TLC5615_TX_HOLD_BUF_EN
                        if (r_buf_full || w_accept) begin
                            r_state <= ST_SETUP;
                            r_shift <= w_launch_word;
                            r_din   <= w_launch_word[FRAME_BITS-1];
                            r_cs_n  <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
`endif
                    end else begin
                        r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs_n  <= 1'b1;
                    r_sclk  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
`ifdef TLC5615_TX_HOLD_BUF_EN
            if (w_buf_push) begin
                r_buf_full <= 1'b1;
                r_buf_data <= sample_in;
                r_ready    <= 1'b0;
            end else if (w_gap_end && r_buf_full) begin
                r_buf_full <= 1'b0;
                r_ready    <= 1'b1;
            end
`endif
        end
    end

    assign sample_ready = r_ready;
    assign dac_cs_n     = r_cs_n;
    assign dac_sclk     = r_sclk;
    assign dac_din      = r_din;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire
